switch_conditioner: RTL and testbench
=====================================

Name: switch_conditioner

Overview:
- Conditions a raw mechanical switch or button input into a clean, glitch-free level plus single-cycle event pulses.
- Sits between the board pin and the LED sequencer's stop/restart input; sw_clean drives that input directly.
- Also reports long presses and a running press count for the sequencer's control and status logic.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on sw_raw (>=2)
DEBOUNCE_CYCLES, 1000000, cycles sw_sync must be stable before a level change is accepted (10 ms at 100 MHz, >=1)
LONG_PRESS_CYCLES, 200000000, cycles in PRESSED before a long press is flagged (2 s at 100 MHz, >=1)
CNT_W, 28, width of the debounce and hold counters; must hold max(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES)
PRESS_CNT_W, 16, width of press_count

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
sw_raw  in  1  asynchronous raw switch level, 1 = pressed
sw_clean  out  1  debounced level, registered
press_pulse  out  1  one-cycle pulse on the accepted press
release_pulse  out  1  one-cycle pulse on the accepted release
long_press_pulse  out  1  one-cycle pulse when a long press is reached
long_held  out  1  high from the long press until the accepted release
press_count  out  PRESS_CNT_W  number of accepted presses, wraps

Behaviour:
- Reset is asynchronous, active-high; clock is clk. While reset is high:
  - sync chain = 0, state = RELEASED, both counters = 0.
  - All outputs = 0.
  - No pulses are emitted on reset entry or exit.
- Synchronizer: SYNC_STAGES flops; sw_sync is the last stage.
- FSM states: RELEASED, PRESS_PENDING, PRESSED, LONG, RELEASE_PENDING. A ret_long bit records whether RELEASE_PENDING was entered from LONG.
- RELEASED:
  - sw_sync=1 -> PRESS_PENDING, debounce counter <= 1.
- PRESS_PENDING:
  - sw_sync=0 -> RELEASED, debounce counter <= 0.
  - sw_sync=1 and counter==DEBOUNCE_CYCLES -> PRESSED; sw_clean<=1, press_pulse<=1, press_count<=press_count+1, hold counter <= 1.
  - Otherwise the counter increments.
- PRESSED:
  - sw_sync=0 -> RELEASE_PENDING, ret_long<=0, debounce counter <= 1.
  - sw_sync=1 and hold counter==LONG_PRESS_CYCLES -> LONG; long_press_pulse<=1, long_held<=1.
  - Otherwise the hold counter increments.
- LONG:
  - sw_sync=0 -> RELEASE_PENDING, ret_long<=1, debounce counter <= 1.
- RELEASE_PENDING:
  - sw_sync=1 -> back to PRESSED or LONG per ret_long. The hold counter is frozen here and resumes unchanged; no pulses.
  - sw_sync=0 and counter==DEBOUNCE_CYCLES -> RELEASED; sw_clean<=0, long_held<=0, release_pulse<=1.
  - Otherwise the counter increments.
- Latency:
  - Edge k is the first edge that samples sw_raw=1 with sw_raw stable afterwards.
  - sw_clean rises and press_pulse is high after edge k+SYNC_STAGES+DEBOUNCE_CYCLES.
  - Release is symmetric.
- Pulses:
  - Each pulse is exactly one cycle.
  - press_pulse and release_pulse are never high together.
  - long_press_pulse fires at most once per press.
- press_count wraps from all-ones to 0 without saturating.
- Bounce shorter than DEBOUNCE_CYCLES produces no output change and no pulse.
- With DEBOUNCE_CYCLES=1, a level must persist for 1 cycle past entry into the pending state.
- Reset mid-press: all outputs clear immediately. After reset, a still-held switch re-debounces from RELEASED and produces a fresh press_pulse.

Decomposition:
- Shared package holds:
  - the state enum, switch_conditioner_state_t.
  - the default timing constants (DEBOUNCE_10MS_100MHZ, LONG_PRESS_2S_100MHZ), shared with the LED sequencer's 500 ms / 1 s constants.
- One sub-module, sync_ff_chain: parameterised SYNC_STAGES flop chain with async reset to 0, reused for other board inputs.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, PRESS_CNT_W=4):
1. Clean press at edge 10, held 8 cycles -> sw_clean rises after edge 16, press_pulse high for one cycle, press_count=1. Release -> sw_clean falls 6 edges after the first 0 sample, with one release_pulse.
2. Bounce: sw_raw toggles 1/0 every 2 cycles for 20 cycles, then stays 0 -> sw_clean stays 0, no pulses, press_count=0.
3. Long hold for 30 cycles -> long_press_pulse exactly once, 10 cycles after press_pulse; long_held=1 until the debounced release; release_pulse once; only one press counted.
4. Release glitch: while PRESSED (hold counter=5), sw_raw low for 2 cycles -> no release_pulse. The hold counter resumes at 5; long_press_pulse comes 5 PRESSED cycles later.
5. Wrap: 17 clean presses -> press_count sequence ends ...15,0,1.
6. Reset asserted mid-LONG with the switch held -> all outputs 0 immediately. After deassert, press_pulse fires again 6 edges later and press_count=1.

Source files
------------

// File: rtl/switch_conditioner_pkg.sv
// Shared types and board timing constants for the switch conditioner and LED sequencer.
package switch_conditioner_pkg;

  typedef enum logic [2:0] {
    RELEASED,
    PRESS_PENDING,
    PRESSED,
    LONG,
    RELEASE_PENDING
  } switch_conditioner_state_t;

  // Default timings for a 100 MHz system clock.
  localparam int unsigned DEBOUNCE_10MS_100MHZ  = 1000000;
  localparam int unsigned LONG_PRESS_2S_100MHZ  = 200000000;
  localparam int unsigned LED_STEP_500MS_100MHZ = 50000000;
  localparam int unsigned LED_PERIOD_1S_100MHZ  = 100000000;

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer for an asynchronous single-bit board input.
module sync_ff_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift the raw level through the chain; oldest sample is the synchronized output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/switch_conditioner.sv
// Debounces a raw switch into a clean level with press/release/long-press pulses
// and a wrapping count of accepted presses.
module switch_conditioner
  import switch_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_10MS_100MHZ,
  parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_2S_100MHZ,
  parameter int unsigned CNT_W             = 28,
  parameter int unsigned PRESS_CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sw_raw,
  output logic                   sw_clean,
  output logic                   press_pulse,
  output logic                   release_pulse,
  output logic                   long_press_pulse,
  output logic                   long_held,
  output logic [PRESS_CNT_W-1:0] press_count
);

  localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic sw_sync;

  switch_conditioner_state_t state_q, state_d;
  logic [CNT_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0]       hold_cnt_q, hold_cnt_d;
  logic                   ret_long_q, ret_long_d;
  logic                   clean_q, clean_d;
  logic                   press_pulse_q, press_pulse_d;
  logic                   release_pulse_q, release_pulse_d;
  logic                   long_pulse_q, long_pulse_d;
  logic                   long_held_q, long_held_d;
  logic [PRESS_CNT_W-1:0] press_count_q, press_count_d;

  sync_ff_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (sw_raw),
    .q_o  (sw_sync)
  );

  // State, counters and registered outputs; everything clears on reset so no pulse escapes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= RELEASED;
      deb_cnt_q       <= '0;
      hold_cnt_q      <= '0;
      ret_long_q      <= 1'b0;
      clean_q         <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_pulse_q    <= 1'b0;
      long_held_q     <= 1'b0;
      press_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      deb_cnt_q       <= deb_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      ret_long_q      <= ret_long_d;
      clean_q         <= clean_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_pulse_q    <= long_pulse_d;
      long_held_q     <= long_held_d;
      press_count_q   <= press_count_d;
    end
  end

  // Debounce/hold FSM: a level is accepted only after staying put for DEBOUNCE_CYCLES
  // past entry into a pending state. The hold counter freezes across a release glitch.
  always_comb begin
    state_d         = state_q;
    deb_cnt_d       = deb_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    ret_long_d      = ret_long_q;
    clean_d         = clean_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    long_pulse_d    = 1'b0;
    long_held_d     = long_held_q;
    press_count_d   = press_count_q;

    case (state_q)
      RELEASED: begin
        if (sw_sync) begin
          state_d   = PRESS_PENDING;
          deb_cnt_d = CNT_ONE;
        end
      end

      PRESS_PENDING: begin
        if (!sw_sync) begin
          state_d   = RELEASED;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LIM) begin
          state_d       = PRESSED;
          clean_d       = 1'b1;
          press_pulse_d = 1'b1;
          press_count_d = press_count_q + PRESS_CNT_W'(1);
          hold_cnt_d    = CNT_ONE;
        end else begin
          deb_cnt_d = deb_cnt_q + CNT_ONE;
        end
      end

      PRESSED: begin
        if (!sw_sync) begin
          state_d    = RELEASE_PENDING;
          ret_long_d = 1'b0;
          deb_cnt_d  = CNT_ONE;
        end else if (hold_cnt_q == HOLD_LIM) begin
          state_d      = LONG;
          long_pulse_d = 1'b1;
          long_held_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_ONE;
        end
      end

      LONG: begin
        if (!sw_sync) begin
          state_d    = RELEASE_PENDING;
          ret_long_d = 1'b1;
          deb_cnt_d  = CNT_ONE;
        end
      end

      RELEASE_PENDING: begin
        if (sw_sync) begin
          // Glitch: return to where we came from with the hold count untouched.
          state_d = ret_long_q ? LONG : PRESSED;
        end else if (deb_cnt_q == DEB_LIM) begin
          state_d         = RELEASED;
          clean_d         = 1'b0;
          long_held_d     = 1'b0;
          release_pulse_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = RELEASED;
      end
    endcase
  end

  assign sw_clean         = clean_q;
  assign press_pulse      = press_pulse_q;
  assign release_pulse    = release_pulse_q;
  assign long_press_pulse = long_pulse_q;
  assign long_held        = long_held_q;
  assign press_count      = press_count_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: scenario tasks checked cycle by cycle against a
// run-length based reference model of the debounce rules.
module tb_switch_conditioner;

  localparam int SYNC_STAGES = 2;
  localparam int DEB         = 4;
  localparam int LONGC       = 10;
  localparam int CNT_W       = 8;
  localparam int PCW         = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sw_raw = 1'b0;
  logic sw_clean, press_pulse, release_pulse, long_press_pulse, long_held;
  logic [PCW-1:0] press_count;

  int vectors = 0;
  int miscompares = 0;

  switch_conditioner #(
    .SYNC_STAGES      (SYNC_STAGES),
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONGC),
    .CNT_W            (CNT_W),
    .PRESS_CNT_W      (PCW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sw_raw          (sw_raw),
    .sw_clean        (sw_clean),
    .press_pulse     (press_pulse),
    .release_pulse   (release_pulse),
    .long_press_pulse(long_press_pulse),
    .long_held       (long_held),
    .press_count     (press_count)
  );

  always #5 clk = ~clk;

  wire  [8:0] obs_vec = {sw_clean, press_pulse, release_pulse, long_press_pulse, long_held, press_count};
  logic [8:0] exp_vec;

  // Reference model: the FSM sees raw delayed by SYNC_STAGES edges; a level is accepted
  // when the synchronized signal has held it for DEB+1 consecutive edges; the long press
  // fires on the LONGC-th edge, after acceptance, whose sample and previous sample are both 1.
  logic hist[$];
  int   run1, run0, pairs;
  logic s, s_prev, m_clean, m_press, m_rel, m_lp, m_held, m_fired;
  logic [PCW-1:0] m_cnt;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      m_press = 1'b0;
      m_rel   = 1'b0;
      m_lp    = 1'b0;
      if (reset) begin
        hist.delete();
        for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(1'b0);
        run1 = 0; run0 = 0; pairs = 0;
        s_prev = 1'b0; m_clean = 1'b0; m_held = 1'b0; m_fired = 1'b0;
        m_cnt = '0;
      end else begin
        s = hist[$];
        hist.push_front(sw_raw);
        void'(hist.pop_back());
        if (s) begin run1 = run1 + 1; run0 = 0; end
        else   begin run0 = run0 + 1; run1 = 0; end
        if (!m_clean && run1 == DEB + 1) begin
          m_clean = 1'b1; m_press = 1'b1; m_cnt = m_cnt + 1'b1; pairs = 0; m_fired = 1'b0;
        end else if (m_clean && run0 == DEB + 1) begin
          m_clean = 1'b0; m_rel = 1'b1; m_held = 1'b0;
        end else if (m_clean && !m_fired && s && s_prev) begin
          pairs = pairs + 1;
          if (pairs == LONGC) begin
            m_fired = 1'b1; m_lp = 1'b1; m_held = 1'b1;
          end
        end
        s_prev = s;
      end
      exp_vec = {m_clean, m_press, m_rel, m_lp, m_held, m_cnt};
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset  = 1'b1;
    sw_raw = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sw_raw = (i >= 1);
      @(negedge clk);
      vectors++;
      if (obs_vec !== 9'd0) begin
        miscompares++;
        $display("FAIL reset_hold cycle %0d: got %b expected %b", i, obs_vec, 9'd0);
      end
    end
    sw_raw = 1'b0;
    reset  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if (obs_vec !== 9'd0 || obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL reset_exit cycle %0d: got %b expected %b", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_clean_press();
    logic pat[$];
    int rise = -1, fall = -1, npress = 0, nrel = 0;
    apply_reset();
    for (int i = 0; i < 3; i++)  pat.push_back(1'b0);
    for (int i = 0; i < 8; i++)  pat.push_back(1'b1);
    for (int i = 0; i < 12; i++) pat.push_back(1'b0);
    for (int i = 0; i < pat.size(); i++) begin
      sw_raw = pat[i];
      @(negedge clk);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL clean_press cycle %0d: got %b expected %b", i, obs_vec, exp_vec);
      end
      if (sw_clean === 1'b1 && rise < 0) rise = i;
      if (sw_clean === 1'b0 && rise >= 0 && fall < 0) fall = i;
      if (press_pulse === 1'b1) npress++;
      if (release_pulse === 1'b1) nrel++;
    end
    vectors++;
    if (rise !== 9 || fall !== 17) begin
      miscompares++;
      $display("FAIL clean_press_latency: rise %0d fall %0d expected 9 17", rise, fall);
    end
    vectors++;
    if (npress !== 1 || nrel !== 1 || press_count !== 4'd1) begin
      miscompares++;
      $display("FAIL clean_press_counts: press %0d rel %0d count %0d expected 1 1 1", npress, nrel, press_count);
    end
  endtask

  task automatic test_bounce();
    logic pat[$];
    int npulse = 0, nclean = 0;
    apply_reset();
    for (int i = 0; i < 20; i++) pat.push_back(((i / 2) % 2) == 0);
    for (int i = 0; i < 12; i++) pat.push_back(1'b0);
    for (int i = 0; i < pat.size(); i++) begin
      sw_raw = pat[i];
      @(negedge clk);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL bounce cycle %0d: got %b expected %b", i, obs_vec, exp_vec);
      end
      if (press_pulse || release_pulse || long_press_pulse) npulse++;
      if (sw_clean) nclean++;
    end
    vectors++;
    if (npulse !== 0 || nclean !== 0 || press_count !== 4'd0) begin
      miscompares++;
      $display("FAIL bounce_quiet: pulses %0d clean %0d count %0d expected 0 0 0", npulse, nclean, press_count);
    end
  endtask

  task automatic test_long_hold();
    logic pat[$];
    int p_idx = -1, l_idx = -1, r_idx = -1, nlong = 0, nrel = 0, nheld = 0;
    apply_reset();
    for (int i = 0; i < 2; i++)  pat.push_back(1'b0);
    for (int i = 0; i < 30; i++) pat.push_back(1'b1);
    for (int i = 0; i < 12; i++) pat.push_back(1'b0);
    for (int i = 0; i < pat.size(); i++) begin
      sw_raw = pat[i];
      @(negedge clk);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL long_hold cycle %0d: got %b expected %b", i, obs_vec, exp_vec);
      end
      if (press_pulse && p_idx < 0) p_idx = i;
      if (long_press_pulse) begin nlong++; if (l_idx < 0) l_idx = i; end
      if (release_pulse) begin nrel++; if (r_idx < 0) r_idx = i; end
      if (long_held) nheld++;
    end
    vectors++;
    if (p_idx !== 8 || l_idx !== 18 || r_idx !== 38) begin
      miscompares++;
      $display("FAIL long_hold_timing: press %0d long %0d rel %0d expected 8 18 38", p_idx, l_idx, r_idx);
    end
    vectors++;
    if (nlong !== 1 || nrel !== 1 || nheld !== 20 || press_count !== 4'd1) begin
      miscompares++;
      $display("FAIL long_hold_counts: long %0d rel %0d held %0d count %0d expected 1 1 20 1",
               nlong, nrel, nheld, press_count);
    end
  endtask

  task automatic test_release_glitch();
    logic pat[$];
    int l_idx = -1, r_idx = -1, nlong = 0;
    apply_reset();
    for (int i = 0; i < 2; i++)  pat.push_back(1'b0);
    for (int i = 0; i < 9; i++)  pat.push_back(1'b1);
    for (int i = 0; i < 2; i++)  pat.push_back(1'b0);
    for (int i = 0; i < 20; i++) pat.push_back(1'b1);
    for (int i = 0; i < 12; i++) pat.push_back(1'b0);
    for (int i = 0; i < pat.size(); i++) begin
      sw_raw = pat[i];
      @(negedge clk);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL glitch cycle %0d: got %b expected %b", i, obs_vec, exp_vec);
      end
      if (long_press_pulse) begin nlong++; if (l_idx < 0) l_idx = i; end
      if (release_pulse && r_idx < 0) r_idx = i;
    end
    vectors++;
    if (l_idx !== 21 || nlong !== 1 || r_idx !== 39 || press_count !== 4'd1) begin
      miscompares++;
      $display("FAIL glitch_resume: long %0d x%0d rel %0d count %0d expected 21 x1 39 1",
               l_idx, nlong, r_idx, press_count);
    end
  endtask

  task automatic test_wrap();
    int npress = 0;
    apply_reset();
    for (int p = 0; p < 17; p++) begin
      for (int i = 0; i < 14; i++) begin
        sw_raw = (i < 7);
        @(negedge clk);
        vectors++;
        if (obs_vec !== exp_vec) begin
          miscompares++;
          $display("FAIL wrap press %0d cycle %0d: got %b expected %b", p, i, obs_vec, exp_vec);
        end
        if (press_pulse) begin
          npress++;
          vectors++;
          if (press_count !== PCW'(npress)) begin
            miscompares++;
            $display("FAIL wrap_count press %0d: got %0d expected %0d", npress, press_count, npress % 16);
          end
        end
      end
    end
    vectors++;
    if (npress !== 17 || press_count !== 4'd1) begin
      miscompares++;
      $display("FAIL wrap_final: presses %0d count %0d expected 17 1", npress, press_count);
    end
  endtask

  task automatic test_reset_mid_long();
    int p_idx = -1;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      sw_raw = 1'b1;
      @(negedge clk);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL mid_long_setup cycle %0d: got %b expected %b", i, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (long_held !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_long_reached: long_held %b expected 1", long_held);
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if (obs_vec !== 9'd0) begin
      miscompares++;
      $display("FAIL mid_long_async_clear: got %b expected %b", obs_vec, 9'd0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (obs_vec !== 9'd0) begin
        miscompares++;
        $display("FAIL mid_long_hold cycle %0d: got %b expected %b", i, obs_vec, 9'd0);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL mid_long_after cycle %0d: got %b expected %b", i, obs_vec, exp_vec);
      end
      if (press_pulse && p_idx < 0) p_idx = i;
    end
    vectors++;
    if (p_idx !== 6 || press_count !== 4'd1) begin
      miscompares++;
      $display("FAIL mid_long_repress: press at %0d count %0d expected 6 1", p_idx, press_count);
    end
  endtask

  task automatic test_random();
    int left = 0;
    logic lvl = 1'b0;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if (left == 0) begin
        lvl  = ~lvl;
        left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 25)) : int'($urandom_range(1, 7));
      end
      left--;
      sw_raw = lvl;
      @(negedge clk);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL random cycle %0d: got %b expected %b", i, obs_vec, exp_vec);
      end
      vectors++;
      if (press_pulse && release_pulse) begin
        miscompares++;
        $display("FAIL random_pulse_overlap cycle %0d: press %b release %b expected not both", i, press_pulse, release_pulse);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold();
    test_release_glitch();
    test_wrap();
    test_reset_mid_long();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
